// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: shared state encoding and sizing helpers for the streaming convolver
package conv_stream_pkg;
  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;
  function automatic int out_width(input int w, input int m);
    return 2 * w + $clog2(m);
  endfunction
  function automatic int n_out(input int n, input int m);
    return n - m + 1;
  endfunction
  localparam int NOUT = n_out(8, 4);
endpackage

// File: rtl/conv_sbuf.sv
// conv_sbuf: single-port sample buffer with write enable and registered read
module conv_sbuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/conv_stream_nm.sv
// conv_stream_nm: streaming valid-mode 1-D convolver, one MAC per cycle.
// Define CONV_STREAM_RELU_EN to clamp negative results to zero.
module conv_stream_nm
  import conv_stream_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int OW = out_width(W, M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         s_data_in_x,
  input  logic                 s_valid_x,
  output logic                 s_ready_x,
  input  logic [W-1:0]         s_data_in_f,
  input  logic                 s_valid_f,
  output logic                 s_ready_f,
  output logic signed [OW-1:0] m_data_out_y,
  output logic                 m_valid_y,
  input  logic                 m_ready_y
);
  localparam int XA = $clog2(N);
  localparam int FA = $clog2(M);
  localparam int XC = $clog2(N + 1);
  localparam int FC = $clog2(M + 1);
  localparam int KW = $clog2(M + 2);
  localparam int OI = (N > M) ? $clog2(n_out(N, M)) : 1;
  state_t state, state_d;
  logic [XC-1:0] x_cnt, x_cnt_n;
  logic [FC-1:0] f_cnt, f_cnt_n;
  logic [OI-1:0] out_idx;
  logic [KW-1:0] k;
  logic [XA-1:0] x_addr;
  logic [FA-1:0] f_addr;
  logic signed [OW-1:0] acc, prod, res;
  logic signed [W-1:0] x_rd, f_rd;
  logic x_wr, f_wr, hs, last;
  assign s_ready_x = state == LOAD && x_cnt < XC'(N);
  assign s_ready_f = state == LOAD && f_cnt < FC'(M);
  assign x_wr = s_valid_x & s_ready_x;
  assign f_wr = s_valid_f & s_ready_f;
  assign x_cnt_n = x_cnt + XC'(x_wr);
  assign f_cnt_n = f_cnt + FC'(f_wr);
  assign hs = m_valid_y & m_ready_y;
  assign last = out_idx == OI'(N - M);
  // write counters address the buffers while loading, the MAC index while computing
  assign x_addr = state == LOAD ? x_cnt[XA-1:0] : XA'(out_idx) + XA'(k);
  assign f_addr = state == LOAD ? f_cnt[FA-1:0] : FA'(k);
  assign prod = OW'(x_rd) * OW'(f_rd);
`ifdef CONV_STREAM_RELU_EN
  assign res = acc[OW-1] ? '0 : acc;
`else
  assign res = acc;
`endif
  conv_sbuf #(.WIDTH(W), .DEPTH(N)) u_xbuf (
    .clk(clk), .we(x_wr), .addr(x_addr), .wdata(s_data_in_x), .rdata(x_rd)
  );
  conv_sbuf #(.WIDTH(W), .DEPTH(M)) u_fbuf (
    .clk(clk), .we(f_wr), .addr(f_addr), .wdata(s_data_in_f), .rdata(f_rd)
  );
  always_comb begin
    state_d = state;
    if (state == LOAD && x_cnt_n == XC'(N) && f_cnt_n == FC'(M)) state_d = CALC;
    else if (state == CALC && k == KW'(M + 1)) state_d = OUT;
    else if (state == OUT && hs) state_d = last ? LOAD : CALC;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= LOAD;
    else state <= state_d;
  // CALC: k=0 issues the first read, k=1..M accumulate, k=M+1 registers the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt <= '0;
      f_cnt <= '0;
      out_idx <= '0;
      k <= '0;
      acc <= '0;
      m_valid_y <= 1'b0;
      m_data_out_y <= '0;
    end else if (state == LOAD) begin
      x_cnt <= x_cnt_n;
      f_cnt <= f_cnt_n;
      k <= '0;
      acc <= '0;
    end else if (state == CALC) begin
      k <= k + KW'(1);
      if (k != '0 && k <= KW'(M)) acc <= acc + prod;
      if (k == KW'(M + 1)) begin
        m_data_out_y <= res;
        m_valid_y <= 1'b1;
      end
    end else if (hs) begin
      m_valid_y <= 1'b0;
      k <= '0;
      acc <= '0;
      if (last) begin
        x_cnt <= '0;
        f_cnt <= '0;
        out_idx <= '0;
      end else out_idx <= out_idx + OI'(1);
    end
  end
endmodule
